muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 131 +++++++++++++
 tb/tb_muldiv_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32x32 multiply / divide unit with HI/LO registers
// Divider datapath is present only when MULDIV_DIV_EN is defined.
module muldiv_unit (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        is_div_q;
  logic        neg_q;

  logic        signed_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;

  assign signed_op = ~op[0];
  assign a_mag     = (signed_op && a[31]) ? (32'd0 - a) : a;
  assign b_mag     = (signed_op && b[31]) ? (32'd0 - b) : b;

  // acc holds {partial product, remaining multiplier}; add then shift right
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

`ifdef MULDIV_DIV_EN
  logic [31:0] a_q;
  logic        b_zero_q;
  logic        rem_neg_q;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ok;
  logic [63:0] div_next;

  // acc holds {partial remainder, dividend bits / quotient bits}
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = (div_shift >= {1'b0, opnd});
  assign div_next  = div_ok ? {div_diff[31:0], acc[30:0], 1'b1}
                            : {div_shift[31:0], acc[30:0], 1'b0};
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      count    <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MULDIV_DIV_EN
      a_q       <= 32'd0;
      b_zero_q  <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count    <= 5'd0;
            is_div_q <= op[1];
            neg_q    <= signed_op & (a[31] ^ b[31]);
            acc      <= {32'd0, op[1] ? a_mag : b_mag};
            opnd     <= op[1] ? b_mag : a_mag;
            busy     <= 1'b1;
`ifdef MULDIV_DIV_EN
            a_q       <= a;
            b_zero_q  <= (b == 32'd0);
            rem_neg_q <= signed_op & a[31];
            state     <= CALC;
`else
            state     <= op[1] ? FIN : CALC;
`endif
          end else begin
            if (hi_we) hi <= a;
            if (lo_we) lo <= a;
          end
        end
        CALC: begin
`ifdef MULDIV_DIV_EN
          if (is_div_q) acc <= div_next;
          else
`endif
          acc <= {mul_sum, acc[31:1]};
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (!is_div_q) begin
            {hi, lo} <= neg_q ? (64'd0 - acc) : acc;
          end
`ifdef MULDIV_DIV_EN
          else if (b_zero_q) begin
            lo <= 32'hFFFF_FFFF;
            hi <= a_q;
          end else begin
            lo <= neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
            hi <= rem_neg_q ? (32'd0 - acc[63:32]) : acc[63:32];
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
// Division expectations follow MULDIV_DIV_EN, matching the RTL build.
module tb_muldiv_unit;

  logic        clock;
  logic        resetn;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        start;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  muldiv_unit dut (
    .clock  (clock),
    .resetn (resetn),
    .a      (a),
    .b      (b),
    .op     (op),
    .start  (start),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Starts one operation on the next edge and returns edges-to-done (-1 on timeout),
  // cycles with busy high, and whether HI/LO were unchanged right after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int cyc, output int bcnt, output logic held);
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    pre_hi = hi;
    pre_lo = lo;
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    held = (hi === pre_hi) && (lo === pre_lo);
    bcnt = busy ? 1 : 0;
    cyc = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clock); #1;
      if (done) begin
        cyc = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    int cyc, bcnt;
    logic held;
    resetn = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = 32'd0; b = 32'd0; op = 2'b00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      fails++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, need all zero", hi, lo, busy, done);
    end
    resetn = 1'b1;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, cyc, bcnt, held);
    tests++;
    if (cyc !== 33) begin
      fails++;
      $display("FAIL mult_latency: got %0d edges after start, need 33", cyc);
    end
    tests++;
    if (bcnt !== 33) begin
      fails++;
      $display("FAIL mult_busy_cycles: got %0d, need 33", bcnt);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_at_done: got %b, need 0", busy);
    end
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      fails++;
      $display("FAIL mult_signed: got %h_%h, need ffffffff_fffffff1", hi, lo);
    end
    @(posedge clock); #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse_width: done=%b one cycle later, need 0", done);
    end
  endtask

  task automatic test_multu;
    int cyc, bcnt;
    logic held;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcnt, held);
    tests++;
    if (held !== 1'b1) begin
      fails++;
      $display("FAIL hilo_held_calc: held=%b, need 1", held);
    end
    tests++;
    if (cyc !== 33 || {hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      fails++;
      $display("FAIL multu_max: got %h_%h after %0d edges, need fffffffe_00000001 after 33", hi, lo, cyc);
    end
    run_op(2'b00, 32'h8000_0000, 32'h0000_0002, cyc, bcnt, held);
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFF_0000_0000) begin
      fails++;
      $display("FAIL mult_minint: got %h_%h, need ffffffff_00000000", hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clock);
    a = 32'h1111_1111; hi_we = 1'b1;
    @(posedge clock); #1;
    hi_we = 1'b0; a = 32'h2222_2222; lo_we = 1'b1;
    @(posedge clock); #1;
    lo_we = 1'b0;
    tests++;
    if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      fails++;
      $display("FAIL mthi_mtlo_separate: got hi=%h lo=%h, need 11111111 22222222", hi, lo);
    end
    a = 32'h5A5A_0F0F; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    tests++;
    if (hi !== 32'h5A5A_0F0F || lo !== 32'h5A5A_0F0F) begin
      fails++;
      $display("FAIL mthi_mtlo_both: got hi=%h lo=%h, need 5a5a0f0f both", hi, lo);
    end
  endtask

  task automatic test_div;
    int cyc, bcnt;
    logic held;
`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, bcnt, held);
    tests++;
    if (cyc !== 33 || bcnt !== 33) begin
      fails++;
      $display("FAIL div_latency: got %0d edges busy %0d, need 33 and 33", cyc, bcnt);
    end
    tests++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL div_signed: got lo=%h hi=%h, need fffffffd ffffffff", lo, hi);
    end
    run_op(2'b11, 32'd7, 32'd0, cyc, bcnt, held);
    tests++;
    if (cyc !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
      fails++;
      $display("FAIL divu_by_zero: got lo=%h hi=%h after %0d, need ffffffff 00000007 after 33", lo, hi, cyc);
    end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcnt, held);
    tests++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      fails++;
      $display("FAIL div_overflow: got lo=%h hi=%h, need 80000000 00000000", lo, hi);
    end
    run_op(2'b11, 32'd100, 32'd7, cyc, bcnt, held);
    tests++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      fails++;
      $display("FAIL divu_basic: got lo=%h hi=%h, need 0000000e 00000002", lo, hi);
    end
`else
    // hi_we alongside an accepted start must be ignored; divide leaves HI/LO alone
    hi_we = 1'b1;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, bcnt, held);
    hi_we = 1'b0;
    tests++;
    if (cyc !== 1 || bcnt !== 1) begin
      fails++;
      $display("FAIL div_skip_latency: got %0d edges busy %0d, need 1 and 1", cyc, bcnt);
    end
    tests++;
    if (hi !== 32'h5A5A_0F0F || lo !== 32'h5A5A_0F0F) begin
      fails++;
      $display("FAIL div_skip_hilo: got hi=%h lo=%h, need 5a5a0f0f both", hi, lo);
    end
    run_op(2'b11, 32'd7, 32'd0, cyc, bcnt, held);
    tests++;
    if (cyc !== 1 || hi !== 32'h5A5A_0F0F || lo !== 32'h5A5A_0F0F) begin
      fails++;
      $display("FAIL divu_skip: got hi=%h lo=%h after %0d, need 5a5a0f0f both after 1", hi, lo, cyc);
    end
`endif
  endtask

  task automatic test_busy;
    int ndone;
    int first_done;
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ndone = 0;
    first_done = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock); #1;
      start = 1'b0; hi_we = 1'b0;
      if (i == 10) begin
        op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
      end
      if (i == 11) begin
        a = 32'h1234; hi_we = 1'b1;
      end
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = i;
      end
    end
    tests++;
    if (ndone !== 1 || first_done !== 33) begin
      fails++;
      $display("FAIL busy_ignore_start: %0d dones first at %0d, need 1 at 33", ndone, first_done);
    end
    tests++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      fails++;
      $display("FAIL busy_result: got hi=%h lo=%h, need 00000000 0000000c", hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    @(negedge clock);
    a = 32'hAAAA; hi_we = 1'b1;
    @(posedge clock); #1;
    hi_we = 1'b0;
    tests++;
    if (hi !== 32'hAAAA) begin
      fails++;
      $display("FAIL mthi_pre_reset: got %h, need 0000aaaa", hi);
    end
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    tests++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: hi=%h lo=%h busy=%b done=%b, need all zero", hi, lo, busy, done);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    tests++;
    if (ndone !== 0 || hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_abandon: %0d dones hi=%h lo=%h busy=%b, need 0 0 0 0", ndone, hi, lo, busy);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_multu;
    test_mthi_mtlo;
    test_div;
    test_busy;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
